// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared scan-code constants, FSM states and event type for the keyboard sequencer.
package kbd_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_NULL = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    DECODE,
    EMIT,
    GAP
  } state_e;

  // "release" is a language keyword, so the break flag is named rel.
  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } kbd_evt_t;

endpackage

// File: rtl/kbd_prefix_decode.sv
// rtl/kbd_prefix_decode.sv - pure classification of the popped byte against prefix flags and held key.
module kbd_prefix_decode
  import kbd_pkg::*;
(
  input  logic       [7:0] byte_i,
  input  logic             ext_i,
  input  logic             brk_i,
  input  logic       [8:0] held_i,
  input  logic             key_held_i,
  output logic             is_prefix,
  output logic             is_null,
  output logic             is_repeat,
  output kbd_evt_t         evt
);

  always_comb begin
    is_null   = (byte_i == SC_NULL);
    is_prefix = (byte_i == SC_EXT) || (byte_i == SC_BRK);
    evt       = '{ext: ext_i, rel: brk_i, code: byte_i};
    // A repeat is a make for the very key (including its E0 bit) still held down.
    is_repeat = !is_null && !is_prefix && !brk_i && key_held_i &&
                ({ext_i, byte_i} == held_i);
  end

endmodule

// File: rtl/kbd_event_sequencer.sv
// rtl/kbd_event_sequencer.sv - drains the PS/2 FIFO, folds E0/F0 prefixes and hands out key events.
// Define KBD_REPEAT_EN to emit typematic repeats as make events flagged on evt_repeat.
module kbd_event_sequencer
  import kbd_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             fifo_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_release,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
`ifdef KBD_REPEAT_EN
  output logic             evt_repeat,
`endif
  output logic             ovf_sticky
);

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic [8:0]       held_q, held_d;
  logic             key_held_q, key_held_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  kbd_evt_t         evt_q, evt_d;
`ifdef KBD_REPEAT_EN
  logic             rep_q, rep_d;
`endif

  logic     is_prefix, is_null, is_repeat;
  kbd_evt_t dec_evt;

  kbd_prefix_decode u_decode (
    .byte_i     (byte_q),
    .ext_i      (ext_q),
    .brk_i      (brk_q),
    .held_i     (held_q),
    .key_held_i (key_held_q),
    .is_prefix  (is_prefix),
    .is_null    (is_null),
    .is_repeat  (is_repeat),
    .evt        (dec_evt)
  );

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    nextdata_n_d = 1'b1;
    ext_d        = ext_q;
    brk_d        = brk_q;
    held_d       = held_q;
    key_held_d   = key_held_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    evt_d        = evt_q;
`ifdef KBD_REPEAT_EN
    rep_d        = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_ready) begin
          byte_d       = fifo_data;
          nextdata_n_d = 1'b0;
          state_d      = POP;
        end
      end
      POP: state_d = DECODE;
      DECODE: begin
        if (is_null) begin
          state_d = GAP;
        end else if (is_prefix) begin
          if (byte_q == SC_EXT) ext_d = 1'b1;
          else                  brk_d = 1'b1;
          state_d = GAP;
        end else begin
          ext_d = 1'b0;
          brk_d = 1'b0;
`ifdef KBD_REPEAT_EN
          rep_d = 1'b0;
`endif
          if (dec_evt.rel) begin
            key_held_d = 1'b0;
            evt_d      = dec_evt;
            state_d    = EMIT;
          end else if (is_repeat) begin
`ifdef KBD_REPEAT_EN
            evt_d   = dec_evt;
            rep_d   = 1'b1;
            state_d = EMIT;
`else
            state_d = GAP;
`endif
          end else begin
            held_d     = {dec_evt.ext, dec_evt.code};
            key_held_d = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
            evt_d      = dec_evt;
            state_d    = EMIT;
          end
        end
      end
      EMIT: begin
        if (evt_ready) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Overflow invalidates any half-received prefix sequence; it beats a prefix set.
    if (fifo_overflow) begin
      ovf_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_q       <= 8'h00;
      nextdata_n_q <= 1'b1;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= 9'h000;
      key_held_q   <= 1'b0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      evt_q        <= '0;
`ifdef KBD_REPEAT_EN
      rep_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      nextdata_n_q <= nextdata_n_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      held_q       <= held_d;
      key_held_q   <= key_held_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      evt_q        <= evt_d;
`ifdef KBD_REPEAT_EN
      rep_q        <= rep_d;
`endif
    end
  end

  assign fifo_nextdata_n = nextdata_n_q;
  assign evt_valid       = (state_q == EMIT);
  assign evt_code        = evt_q.code;
  assign evt_ext         = evt_q.ext;
  assign evt_release     = evt_q.rel;
  assign key_held        = key_held_q;
  assign press_count     = cnt_q;
  assign ovf_sticky      = ovf_q;
`ifdef KBD_REPEAT_EN
  assign evt_repeat      = rep_q;
`endif

endmodule

// File: tb/tb_kbd_event_sequencer.sv
// tb/tb_kbd_event_sequencer.sv - bench for kbd_event_sequencer with a FIFO model and event scoreboard.
module tb_kbd_event_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] fifo_data;
  logic       fifo_ready;
  logic       fifo_overflow;
  logic       fifo_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic       key_held;
  logic [7:0] press_count;
  logic       ovf_sticky;
  logic       rep_s;

  always #5 clk = ~clk;

  kbd_event_sequencer #(.CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .fifo_data       (fifo_data),
    .fifo_ready      (fifo_ready),
    .fifo_overflow   (fifo_overflow),
    .fifo_nextdata_n (fifo_nextdata_n),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_code        (evt_code),
    .evt_ext         (evt_ext),
    .evt_release     (evt_release),
    .key_held        (key_held),
    .press_count     (press_count),
`ifdef KBD_REPEAT_EN
    .evt_repeat      (rep_s),
`endif
    .ovf_sticky      (ovf_sticky)
  );
`ifndef KBD_REPEAT_EN
  assign rep_s = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: events are {rep, ext, rel, code}.
  logic [7:0]  fifo_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  logic        m_ext = 0, m_brk = 0, m_held = 0;
  logic [8:0]  m_held_code = 0;
  int          m_count = 0;
  int          pops = 0;
  bit          drop_next_pop = 0;

  task automatic model_byte(input logic [7:0] b);
    logic e, r;
    if (b == 8'h00) return;
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    e = m_ext; r = m_brk;
    m_ext = 0; m_brk = 0;
    if (r) begin
      m_held = 0;
      exp_q.push_back({1'b0, e, 1'b1, b});
    end else if (m_held && m_held_code == {e, b}) begin
`ifdef KBD_REPEAT_EN
      exp_q.push_back({1'b1, e, 1'b0, b});
`endif
    end else begin
      m_held = 1;
      m_held_code = {e, b};
      m_count++;
      exp_q.push_back({1'b0, e, 1'b0, b});
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_held_code = 0; m_count = 0;
    exp_q.delete();
  endtask

  // FIFO model: the head leaves on the single low cycle of fifo_nextdata_n.
  always @(negedge clk) begin
    logic [7:0] b;
    if (fifo_nextdata_n === 1'b0 && fifo_q.size() > 0) begin
      b = fifo_q.pop_front();
      if (drop_next_pop) drop_next_pop = 0;
      else model_byte(b);
    end
    fifo_ready = (fifo_q.size() != 0);
    fifo_data  = fifo_ready ? fifo_q[0] : 8'h00;
  end

  // Compare process: pop pulse shape, backpressure stability, scoreboard at each handshake.
  logic        prev_n = 1'b1;
  bit          hold_active = 0;
  logic [10:0] saved;
  always @(negedge clk) begin
    logic [10:0] act;
    act = {rep_s, evt_ext, evt_release, evt_code};
    if (rst === 1'b1) begin
      if (fifo_nextdata_n === 1'b0) begin
        pops++;
        check("pop_pulse_one_cycle", prev_n, 1);
      end
      if (evt_valid === 1'b1) begin
        check("no_pop_while_valid", fifo_nextdata_n, 1);
        if (hold_active) check("payload_stable", act, saved);
        saved = act;
        hold_active = 1;
        if (evt_ready) begin
          hold_active = 0;
          got_q.push_back(act);
          if (exp_q.size() == 0) check("unexpected_event", act, 11'h7FF);
          else check("event_payload", act, exp_q.pop_front());
        end
      end else begin
        hold_active = 0;
      end
    end
    prev_n = fifo_nextdata_n;
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic drain();
    int n = 0;
    while (fifo_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", n < 20000, 1);
    repeat (12) @(negedge clk);
  endtask

  task automatic check_model(input string name);
    check({name, "_press_count"}, press_count, m_count & 255);
    check({name, "_key_held"}, key_held, m_held);
  endtask

  initial begin
    int p0, g0, c0, n;
    logic [7:0] code;
    rst = 0; evt_ready = 1; fifo_overflow = 0;
    fifo_ready = 0; fifo_data = 0;
    repeat (3) @(negedge clk);
    check("rst_nextdata_n", fifo_nextdata_n, 1);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_code", evt_code, 0);
    check("rst_ext_rel", {evt_ext, evt_release}, 0);
    check("rst_key_held", key_held, 0);
    check("rst_press_count", press_count, 0);
    check("rst_ovf_sticky", ovf_sticky, 0);
    rst = 1;
    @(negedge clk);

    // Make then break of 1C.
    p0 = pops; g0 = got_q.size();
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("t1_pops", pops - p0, 3);
    check("t1_events", got_q.size() - g0, 2);
    check("t1_ev0", got_q[g0], 11'h01C);
    check("t1_ev1", got_q[g0+1], 11'h11C);
    check("t1_press_count", press_count, 1);
    check("t1_key_held", key_held, 0);
    check_model("t1");

    // Extended key make/break, prefix bytes silent.
    g0 = got_q.size();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("t2_events", got_q.size() - g0, 2);
    check("t2_ev0", got_q[g0], 11'h275);
    check("t2_ev1", got_q[g0+1], 11'h375);
    check_model("t2");

    // Typematic repeats.
    g0 = got_q.size(); c0 = press_count;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    check("t3_press_count", press_count, (c0 + 1) & 255);
`ifdef KBD_REPEAT_EN
    check("t3_events", got_q.size() - g0, 4);
    check("t3_ev1", got_q[g0+1], 11'h41C);
    check("t3_ev2", got_q[g0+2], 11'h41C);
    check("t3_ev3", got_q[g0+3], 11'h11C);
`else
    check("t3_events", got_q.size() - g0, 2);
    check("t3_ev1", got_q[g0+1], 11'h11C);
`endif
    check("t3_ev0", got_q[g0], 11'h01C);
    check_model("t3");

    // Backpressure with three bytes queued.
    evt_ready = 0; p0 = pops; g0 = got_q.size();
    push(8'h2A); push(8'hF0); push(8'h2A);
    repeat (20) @(negedge clk);
    check("t4_valid_held", evt_valid, 1);
    check("t4_code_held", evt_code, 8'h2A);
    check("t4_single_pop", pops - p0, 1);
    evt_ready = 1;
    drain();
    check("t4_events", got_q.size() - g0, 2);
    check("t4_ev0", got_q[g0], 11'h02A);
    check("t4_ev1", got_q[g0+1], 11'h12A);
    check_model("t4");

    // Overflow after an E0 prefix discards the prefix.
    g0 = got_q.size();
    push(8'hE0);
    drain();
    check("t5_ovf_before", ovf_sticky, 0);
    fifo_overflow = 1; m_ext = 0; m_brk = 0;
    @(negedge clk);
    fifo_overflow = 0;
    check("t5_ovf_set", ovf_sticky, 1);
    push(8'h1C);
    drain();
    check("t5_events", got_q.size() - g0, 1);
    check("t5_ev0", got_q[g0], 11'h01C);
    check("t5_ovf_sticky", ovf_sticky, 1);
    check_model("t5");

    // Reset during the pop cycle.
    g0 = got_q.size();
    drop_next_pop = 1;
    push(8'h33);
    n = 0;
    while (fifo_nextdata_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_pop_seen", n < 50, 1);
    rst = 0;
    model_reset();
    @(negedge clk);
    check("t6_nextdata_n", fifo_nextdata_n, 1);
    check("t6_evt_valid", evt_valid, 0);
    check("t6_payload", {evt_ext, evt_release, evt_code}, 0);
    check("t6_key_held", key_held, 0);
    check("t6_press_count", press_count, 0);
    check("t6_ovf_sticky", ovf_sticky, 0);
    rst = 1;
    repeat (12) @(negedge clk);
    check("t6_no_event", got_q.size() - g0, 0);
    check("t6_valid_after", evt_valid, 0);

    // 256 make/break pairs wrap press_count to 0.
    g0 = got_q.size();
    for (int i = 0; i < 256; i++) begin
      code = 8'((i % 200) + 1);
      if (i >= 200) begin
        push(8'hE0); push(code); push(8'hE0); push(8'hF0); push(code);
      end else begin
        push(code); push(8'hF0); push(code);
      end
    end
    drain();
    check("t7_events", got_q.size() - g0, 512);
    check("t7_press_wrap", press_count, 0);
    check("t7_key_held", key_held, 0);
    check_model("t7");

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_event_sequencer.md
Name: kbd_event_sequencer

Overview:
- Drains the PS/2 receiver FIFO (ps2_keyboard) with a correct one-pulse nextdata_n pop handshake.
- Folds E0/F0 prefix bytes into single key events and suppresses typematic repeats.
- Presents events to downstream consumers (display, ASCII mapper) over a valid/ready interface.
- Sits between ps2_keyboard and all keyboard consumers; it is the only agent allowed to pop the FIFO.

Parameters:
CNT_W, 8, width of press_count (wraps modulo 2^CNT_W)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
fifo_data  in  8  head byte from ps2_keyboard
fifo_ready  in  1  FIFO non-empty
fifo_overflow  in  1  FIFO overflow indication
fifo_nextdata_n  out  1  pop strobe, active-low, registered
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_code  out  8  scan code (prefixes stripped)
evt_ext  out  1  code was E0-prefixed
evt_release  out  1  break (F0) event; 0 = make
key_held  out  1  a non-repeat make is outstanding
press_count  out  CNT_W  accepted make events (repeats excluded)
ovf_sticky  out  1  overflow seen since reset

Behaviour:
- Clock and reset: clk; rst synchronous, active-low.
- Reset values:
  - fifo_nextdata_n=1; evt_valid=0; evt_code=0; evt_ext=0; evt_release=0.
  - key_held=0; press_count=0; ovf_sticky=0.
  - Prefix flags ext_q=brk_q=0; held code register=0; state=IDLE.
- Reset mid-operation: any in-flight byte or event is discarded, and no pop is issued in the reset cycle.
- FSM states: IDLE, POP, DECODE, EMIT, GAP.
- IDLE: if fifo_ready=1 in cycle N, capture fifo_data into byte_q, drive fifo_nextdata_n=0 for cycle N+1 only, and go to POP.
- POP: fifo_nextdata_n returns to 1; go to DECODE.
- DECODE, selected by byte_q:
  - 8'h00: discard; go to GAP.
  - 8'hE0: ext_q<=1; go to GAP.
  - 8'hF0: brk_q<=1; go to GAP.
  - Any other byte forms event {ext_q, brk_q, byte_q}; clear ext_q and brk_q.
  - Break event: key_held<=0; emit.
  - Make whose {ext, code} equals the held register while key_held=1: typematic repeat; drop it; go to GAP.
  - Other make: load held register; key_held<=1; press_count+=1 (wraps); emit.
- EMIT: evt_valid=1 with payload held stable until evt_valid&&evt_ready, then go to GAP. No FIFO pop occurs while in EMIT (backpressure stalls draining).
- GAP: one idle cycle so the FIFO head and fifo_ready settle after the pop; then IDLE.
- Latency with evt_ready=1: fifo_ready sampled in cycle N gives evt_valid in cycle N+3. Minimum byte-to-byte spacing is 4 cycles (5 when emitting).
- Overflow: fifo_overflow=1 in any cycle sets ovf_sticky and clears ext_q and brk_q at the next edge. The FIFO is still drained normally.
- Simultaneous overflow and prefix decode: the overflow clear wins.
- Break for a code other than the held code: the event is still emitted and key_held is cleared.

Optional Feature:
KBD_REPEAT_EN
- Defined:
  - Typematic repeats are emitted as make events.
  - Adds an output port evt_repeat (1 bit, 1 on repeat events, 0 otherwise).
  - press_count is still not incremented for repeats.
- Undefined: repeats are dropped as described above, and the evt_repeat port does not exist.

Decomposition:
- kbd_pkg holds:
  - Constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_NULL=8'h00.
  - State enum (IDLE, POP, DECODE, EMIT, GAP).
  - Packed event struct {ext, release, code}.
- One natural sub-module: kbd_prefix_decode, pure decode of byte_q, ext_q, brk_q and the held register into {is_prefix, is_null, is_repeat, event}. The FSM, counters and handshake stay in the top.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1:
  - Events {code=1C, release=0} then {code=1C, release=1}.
  - press_count=1; key_held ends 0.
  - Exactly 3 one-cycle fifo_nextdata_n low pulses.
- Bytes E0, 75, E0, F0, 75: events {75, ext=1, rel=0} and {75, ext=1, rel=1}; no events for prefix bytes.
- Bytes 1C, 1C, 1C, F0, 1C:
  - Without macro: 2 events; press_count=1.
  - With KBD_REPEAT_EN: 4 events, the middle two with evt_repeat=1.
- evt_ready=0 for 20 cycles with 3 bytes queued: evt_valid held and payload stable; fifo_nextdata_n stays 1 until the handshake completes.
- fifo_overflow pulse after byte E0, then byte 1C: ovf_sticky=1 and the event has ext=0.
- rst=0 asserted during POP: next cycle all outputs are at reset values and no event is produced for that byte.
- 256 distinct make/break pairs with CNT_W=8: press_count wraps to 0.
